// File: rtl/onehot_result_tally.sv
// onehot_result_tally
//   Consumer of the dual 2-to-4 decoder/mux stage. Accepts the 4-bit
//   `result` word on a valid/ready handshake. It classifies the word as
//   one-hot, all-zero or multi-hot. It keeps saturating counters of what it has seen.
//
// Handshake (valid/ready): a word transfers on a rising edge where
//   res_valid && res_ready. The producer holds res_valid and res_in
//   stable until that edge. res_ready is high only in IDLE with no clear
//   pending. res_in is a don't-care whenever it is not being accepted.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   res_in/res_valid  incoming result word and its valid
//   res_ready         block can accept a word this cycle
//   clr               clear all counters and err_flag (taken only in IDLE)
//   code/code_valid   last one-hot code, 1-cycle update pulse
//   zero_seen         1-cycle pulse: last word was all-zero
//   err_flag          sticky: multi-hot word seen since reset/clear
//   rd_sel/rd_cnt     combinational read of hit counter [rd_sel]
//   zero_cnt/err_cnt  all-zero and multi-hot word counts
//   dbg_state         current FSM state encoding
module onehot_result_tally #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       res_in,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic             clr,
    output logic [1:0]       code,
    output logic             code_valid,
    output logic             zero_seen,
    output logic             err_flag,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAPT  = 3'd1,
        S_CLASS = 3'd2,
        S_UPD   = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        C_ONE  = 2'd0,
        C_ZERO = 2'd1,
        C_ERR  = 2'd2
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, next_state;
    logic [3:0]       cap_reg;
    cls_t             cls;
    logic [1:0]       enc;
    logic [1:0]       idx;
    logic [CNT_W-1:0] hit_cnt [4];

    logic             accept;
    logic [2:0]       pop;
    cls_t             cls_d;
    logic [1:0]       enc_d;

    assign res_ready = (state == S_IDLE) && !clr;
    assign accept    = res_valid && res_ready;
    assign rd_cnt    = hit_cnt[rd_sel];
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; clr has priority over res_valid in IDLE
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (clr)            next_state = S_CLEAR;
                else if (res_valid) next_state = S_CAPT;
            end
            S_CAPT:  next_state = S_CLASS;
            S_CLASS: next_state = S_UPD;
            S_UPD:   next_state = S_IDLE;
            S_CLEAR: if (idx == 2'd3) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Classification of the captured word
    always_comb begin
        pop   = {2'b00, cap_reg[0]} + {2'b00, cap_reg[1]}
              + {2'b00, cap_reg[2]} + {2'b00, cap_reg[3]};
        enc_d = 2'd0;
        case (cap_reg)
            4'b0010: enc_d = 2'd1;
            4'b0100: enc_d = 2'd2;
            4'b1000: enc_d = 2'd3;
            default: enc_d = 2'd0;
        endcase
        if (pop == 3'd1)      cls_d = C_ONE;
        else if (pop == 3'd0) cls_d = C_ZERO;
        else                  cls_d = C_ERR;
    end

    // Datapath: capture, classify, update, clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_reg    <= 4'b0000;
            cls        <= C_ZERO;
            enc        <= 2'd0;
            idx        <= 2'd0;
            code       <= 2'd0;
            code_valid <= 1'b0;
            zero_seen  <= 1'b0;
            err_flag   <= 1'b0;
            zero_cnt   <= '0;
            err_cnt    <= '0;
            for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
        end else begin
            // Pulses default low; only the UPD edge raises them
            code_valid <= 1'b0;
            zero_seen  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) cap_reg <= res_in;
                    if (clr)    idx     <= 2'd0;
                end
                S_CLASS: begin
                    cls <= cls_d;
                    enc <= enc_d;
                end
                S_UPD: begin
                    case (cls)
                        C_ONE: begin
                            if (hit_cnt[enc] != CNT_MAX) hit_cnt[enc] <= hit_cnt[enc] + 1'b1;
                            code       <= enc;
                            code_valid <= 1'b1;
                        end
                        C_ZERO: begin
                            if (zero_cnt != CNT_MAX) zero_cnt <= zero_cnt + 1'b1;
                            zero_seen <= 1'b1;
                        end
                        default: begin
                            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                            err_flag <= 1'b1;
                        end
                    endcase
                end
                S_CLEAR: begin
                    // One hit counter per cycle; the shared counters go on the last step
                    hit_cnt[idx] <= '0;
                    idx          <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        zero_cnt <= '0;
                        err_cnt  <= '0;
                        err_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_result_tally.sv
module tb_onehot_result_tally;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] res_in;
  logic       res_valid;
  logic       clr;
  logic [1:0] rd_sel;

  logic       res_ready, code_valid, zero_seen, err_flag;
  logic [1:0] code;
  logic [7:0] rd_cnt, zero_cnt, err_cnt;
  logic [2:0] dbg_state;

  logic       res_ready_s, code_valid_s, zero_seen_s, err_flag_s;
  logic [1:0] code_s;
  logic [1:0] rd_cnt_s, zero_cnt_s, err_cnt_s;
  logic [2:0] dbg_state_s;

  int n_vec  = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  onehot_result_tally #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .res_in(res_in), .res_valid(res_valid),
    .res_ready(res_ready), .clr(clr), .code(code), .code_valid(code_valid),
    .zero_seen(zero_seen), .err_flag(err_flag), .rd_sel(rd_sel),
    .rd_cnt(rd_cnt), .zero_cnt(zero_cnt), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  // narrow-counter instance on the same stimulus, for saturation
  onehot_result_tally #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .res_in(res_in), .res_valid(res_valid),
    .res_ready(res_ready_s), .clr(clr), .code(code_s), .code_valid(code_valid_s),
    .zero_seen(zero_seen_s), .err_flag(err_flag_s), .rd_sel(rd_sel),
    .rd_cnt(rd_cnt_s), .zero_cnt(zero_cnt_s), .err_cnt(err_cnt_s),
    .dbg_state(dbg_state_s)
  );

  typedef struct {
    logic [3:0] w;
    logic [1:0] sel;
    logic [1:0] code;
    logic       cv;
    logic       zs;
    logic       ef;
    logic [7:0] zc;
    logic [7:0] ec;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [11];

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one word, wait for acceptance, check busy window.
  // Returns at the negedge after accept+3, when results are visible.
  task automatic xfer(input logic [3:0] w, input string tag);
    int n;
    n = 0;
    res_in    = w;
    res_valid = 1'b1;
    while (!res_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_ready) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    res_in    = 4'b1111;  // junk while busy, must be ignored
    chk({tag, "_busy0"}, res_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_busy1"}, res_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_busy2"}, res_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_ready_again"}, res_ready, 1'b1);
  endtask

  // driver: clear request, optionally with a word presented at the same time
  task automatic do_clear(input logic with_word, input logic [3:0] w);
    clr       = 1'b1;
    res_valid = with_word;
    res_in    = w;
    #1;
    chk("clr_ready_low", res_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clr_busy%0d", i), res_ready, 1'b0);
      @(negedge clk);
    end
    chk("clr_done_ready", res_ready, 1'b1);
    chk("clr_zero_cnt", zero_cnt, 8'd0);
    chk("clr_err_cnt", err_cnt, 8'd0);
    chk("clr_err_flag", err_flag, 1'b0);
    for (int s = 0; s < 4; s++) begin
      rd_sel = s[1:0];
      #1;
      chk($sformatf("clr_hit%0d", s), rd_cnt, 8'd0);
    end
  endtask

  function automatic logic [1:0] enc_of(input logic [3:0] w);
    logic [1:0] e;
    e = 2'd0;
    for (int b = 0; b < 4; b++) if (w[b]) e = b[1:0];
    return e;
  endfunction

  initial begin
    int cv_seen;
    logic [7:0] exp_q [$];
    logic [7:0] m_hit [4];
    logic [7:0] m_zero, m_err;
    int n_cv, n_zs;

    //          w        sel   code  cv    zs    ef    zc     ec     rd
    vecs[0]  = '{4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1};
    vecs[1]  = '{4'b0010, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1};
    vecs[2]  = '{4'b0100, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1};
    vecs[3]  = '{4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1};
    vecs[4]  = '{4'b0000, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 8'd1};
    vecs[5]  = '{4'b0110, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd1};
    vecs[6]  = '{4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd2};
    vecs[7]  = '{4'b1111, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd2};
    vecs[8]  = '{4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 8'd1, 8'd2, 8'd2};
    vecs[9]  = '{4'b0000, 2'd1, 2'd3, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2, 8'd1};
    vecs[10] = '{4'b1010, 2'd2, 2'd3, 1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 8'd1};

    rst_n = 1'b0; res_in = 4'b0000; res_valid = 1'b0; clr = 1'b0; rd_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_ready", res_ready, 1'b1);
    chk("rst_code", code, 2'd0);
    chk("rst_cv", code_valid, 1'b0);
    chk("rst_zs", zero_seen, 1'b0);
    chk("rst_ef", err_flag, 1'b0);
    chk("rst_zc", zero_cnt, 8'd0);
    chk("rst_ec", err_cnt, 8'd0);
    chk("rst_state", dbg_state, 3'd0);

    // T1: reset while a word sits in CLASS
    res_in = 4'b0100; res_valid = 1'b1; rd_sel = 2'd2;
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    chk("t1_in_class", dbg_state, 3'd2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t1_ready", res_ready, 1'b1);
    chk("t1_code", code, 2'd0);
    chk("t1_ef", err_flag, 1'b0);
    chk("t1_rd2", rd_cnt, 8'd0);
    cv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (code_valid || zero_seen) cv_seen++;
      @(negedge clk);
    end
    chk("t1_no_pulse", cv_seen, 0);
    chk("t1_rd2_after", rd_cnt, 8'd0);

    // T2/T3: table-driven sweep
    for (int v = 0; v < 11; v++) begin
      rd_sel = vecs[v].sel;
      xfer(vecs[v].w, $sformatf("v%0d", v));
      chk($sformatf("v%0d_code", v), code, vecs[v].code);
      chk($sformatf("v%0d_cv", v), code_valid, vecs[v].cv);
      chk($sformatf("v%0d_zs", v), zero_seen, vecs[v].zs);
      chk($sformatf("v%0d_ef", v), err_flag, vecs[v].ef);
      chk($sformatf("v%0d_zc", v), zero_cnt, vecs[v].zc);
      chk($sformatf("v%0d_ec", v), err_cnt, vecs[v].ec);
      chk($sformatf("v%0d_rd", v), rd_cnt, vecs[v].rd);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", v), {code_valid, zero_seen}, 2'b00);
    end

    // T5: clr and a word together; clr wins, word accepted afterwards
    do_clear(1'b1, 4'b0001);
    rd_sel = 2'd0;
    xfer(4'b0001, "t5");
    chk("t5_cv", code_valid, 1'b1);
    chk("t5_code", code, 2'd0);
    chk("t5_rd0", rd_cnt, 8'd1);
    chk("t5_ef", err_flag, 1'b0);

    // T4: saturation on the 2-bit instance
    rd_sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back((i + 1 > 3) ? 8'd3 : 8'(i + 1));
    end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      xfer(4'b0100, $sformatf("t4_%0d", i));
      e = exp_q.pop_front();
      chk($sformatf("t4_%0d_sat_rd", i), {6'd0, rd_cnt_s}, e);
      chk($sformatf("t4_%0d_sat_cv", i), code_valid_s, 1'b1);
      chk($sformatf("t4_%0d_sat_code", i), code_s, 2'd2);
      chk($sformatf("t4_%0d_wide_rd", i), rd_cnt, 8'(i + 1));
    end

    // T6: res_valid held with changing data
    do_clear(1'b0, 4'b0000);
    for (int s = 0; s < 4; s++) m_hit[s] = 8'd0;
    m_zero = 8'd0; m_err = 8'd0; n_cv = 0; n_zs = 0;
    res_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] w;
      w = 4'((i * 7 + 3) % 16);
      res_in = w;
      #1;
      if (code_valid) n_cv++;
      if (zero_seen)  n_zs++;
      if (res_ready) begin
        if ($countones(w) == 1)      m_hit[enc_of(w)]++;
        else if ($countones(w) == 0) m_zero++;
        else                         m_err++;
      end
      @(negedge clk);
    end
    res_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (code_valid) n_cv++;
      if (zero_seen)  n_zs++;
      @(negedge clk);
    end
    for (int s = 0; s < 4; s++) begin
      rd_sel = s[1:0];
      #1;
      chk($sformatf("t6_hit%0d", s), rd_cnt, m_hit[s]);
    end
    chk("t6_zc", zero_cnt, m_zero);
    chk("t6_ec", err_cnt, m_err);
    chk("t6_cv_pulses", n_cv, 32'(m_hit[0] + m_hit[1] + m_hit[2] + m_hit[3]));
    chk("t6_zs_pulses", n_zs, 32'(m_zero));
    chk("t6_ef", err_flag, (m_err != 0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
